// File: rtl/traffic_phase_scheduler.sv
// Two-road signal phase scheduler with emergency holds and pause/freeze.
// Define PED_PHASE_EN to add the pedestrian all-red phase after YB.
module traffic_phase_scheduler #(
    parameter int T_GA  = 35,
    parameter int T_GB  = 25,
    parameter int T_Y   = 5,
    parameter int T_PED = 15
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_tick,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_emg_a,
    input  logic       i_emg_b,
    input  logic       i_req_b,
    input  logic       i_req_p,
    output logic       o_r1,
    output logic       o_g1,
    output logic       o_y1,
    output logic       o_r2,
    output logic       o_g2,
    output logic       o_y2,
    output logic [7:0] o_cnt_a,
    output logic [7:0] o_cnt_b,
    output logic       o_blank,
    output logic [2:0] o_phase,
    output logic       o_walk
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GA     = 3'd1,
        S_YA     = 3'd2,
        S_GB     = 3'd3,
        S_YB     = 3'd4,
        S_HOLD_A = 3'd5,
        S_HOLD_B = 3'd6,
        S_PED    = 3'd7
    } state_t;

    localparam logic [7:0] L_GA   = 8'(T_GA);
    localparam logic [7:0] L_GA_B = 8'(T_GA + T_Y);
    localparam logic [7:0] L_GB   = 8'(T_GB);
    localparam logic [7:0] L_GB_A = 8'(T_GB + T_Y);
    localparam logic [7:0] L_Y    = 8'(T_Y);
    localparam logic [7:0] L_PED  = 8'(T_PED);

    state_t     r_state, w_nxt;
    logic [7:0] r_cnt_a, r_cnt_b, w_cnt_a, w_cnt_b, w_cur;
    logic       r_pend_b, w_pend_b, w_pend_p;
    logic       w_set_b, w_clr_b, w_clr_all;
    logic [5:0] r_lamp, w_lamp;
    logic       r_blank, w_blank;

    always_comb begin
        w_nxt     = r_state;
        w_cnt_a   = r_cnt_a;
        w_cnt_b   = r_cnt_b;
        w_clr_b   = 1'b0;
        w_clr_all = 1'b0;
        w_cur     = r_cnt_a;
        if (r_state == S_GB || r_state == S_YB)
            w_cur = r_cnt_b;
        if (i_emg_a) begin
            w_nxt   = S_HOLD_A;
            w_cnt_a = 8'd0;
            w_cnt_b = 8'd0;
        end else if (i_emg_b) begin
            w_nxt   = S_HOLD_B;
            w_cnt_a = 8'd0;
            w_cnt_b = 8'd0;
        end else if (r_state == S_HOLD_A) begin
            w_nxt   = S_GA;
            w_cnt_a = L_GA;
            w_cnt_b = L_GA_B;
        end else if (r_state == S_HOLD_B) begin
            w_nxt   = S_YB;
            w_cnt_a = L_Y;
            w_cnt_b = L_Y;
        end else if (!i_start) begin
            w_nxt     = S_IDLE;
            w_cnt_a   = 8'd0;
            w_cnt_b   = 8'd0;
            w_clr_all = 1'b1;
        end else if (r_state == S_IDLE) begin
            w_nxt   = S_GA;
            w_cnt_a = L_GA;
            w_cnt_b = L_GA_B;
        end else if (i_pause || !i_tick) begin
            w_nxt = r_state;
        end else if (w_cur != 8'd1) begin
            w_cnt_a = r_cnt_a - 8'd1;
            w_cnt_b = r_cnt_b - 8'd1;
        end else begin
            unique case (r_state)
                S_GA: begin
                    if (r_pend_b) begin
                        w_nxt   = S_YA;
                        w_cnt_a = L_Y;
                        w_cnt_b = L_Y;
                    end else begin
                        w_cnt_a = L_GA;
                        w_cnt_b = L_GA_B;
                    end
                end
                S_YA: begin
                    w_nxt   = S_GB;
                    w_cnt_a = L_GB_A;
                    w_cnt_b = L_GB;
                    w_clr_b = 1'b1;
                end
                S_GB: begin
                    w_nxt   = S_YB;
                    w_cnt_a = L_Y;
                    w_cnt_b = L_Y;
                end
                S_YB: begin
                    if (w_pend_p) begin
                        w_nxt   = S_PED;
                        w_cnt_a = L_PED;
                        w_cnt_b = L_PED;
                    end else begin
                        w_nxt   = S_GA;
                        w_cnt_a = L_GA;
                        w_cnt_b = L_GA_B;
                    end
                end
                default: begin
                    w_nxt   = S_GA;
                    w_cnt_a = L_GA;
                    w_cnt_b = L_GA_B;
                end
            endcase
        end
    end

    // A new request in the same cycle as the YA->GB clear keeps pend_b set.
    assign w_set_b  = i_req_b && !(r_state == S_GB || r_state == S_YB
                                   || r_state == S_HOLD_B);
    assign w_pend_b = !w_clr_all && (w_set_b || (r_pend_b && !w_clr_b));

    always_comb begin
        w_lamp  = 6'b100100;
        w_blank = 1'b0;
        case (w_nxt)
            S_IDLE:           w_blank = 1'b1;
            S_GA:             w_lamp  = 6'b010100;
            S_YA:             w_lamp  = 6'b001100;
            S_GB:             w_lamp  = 6'b100010;
            S_YB:             w_lamp  = 6'b100001;
            S_HOLD_A: begin
                w_lamp  = 6'b010100;
                w_blank = 1'b1;
            end
            S_HOLD_B: begin
                w_lamp  = 6'b100010;
                w_blank = 1'b1;
            end
            default:          w_lamp  = 6'b100100;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state  <= S_IDLE;
            r_cnt_a  <= 8'd0;
            r_cnt_b  <= 8'd0;
            r_pend_b <= 1'b0;
            r_lamp   <= 6'b100100;
            r_blank  <= 1'b1;
        end else begin
            r_state  <= w_nxt;
            r_cnt_a  <= w_cnt_a;
            r_cnt_b  <= w_cnt_b;
            r_pend_b <= w_pend_b;
            r_lamp   <= w_lamp;
            r_blank  <= w_blank;
        end
    end

`ifdef PED_PHASE_EN
    logic r_pend_p, r_walk;

    assign w_pend_p = r_pend_p;

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_pend_p <= 1'b0;
            r_walk   <= 1'b0;
        end else begin
            r_pend_p <= !w_clr_all && (i_req_p || (r_pend_p && w_nxt != S_PED));
            r_walk   <= (w_nxt == S_PED);
        end
    end

    assign o_walk = r_walk;
`else
    logic w_unused_req_p;

    assign w_unused_req_p = i_req_p;
    assign w_pend_p       = 1'b0;
    assign o_walk         = 1'b0;
`endif

    assign {o_r1, o_g1, o_y1, o_r2, o_g2, o_y2} = r_lamp;
    assign o_cnt_a = r_cnt_a;
    assign o_cnt_b = r_cnt_b;
    assign o_blank = r_blank;
    assign o_phase = r_state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler with default timing values.
// Honours PED_PHASE_EN when the design is built with it.
module tb_traffic_phase_scheduler;
`ifdef PED_PHASE_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0, tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic       emg_a = 1'b0, emg_b = 1'b0, req_b = 1'b0, req_p = 1'b0;
    logic       r1, g1, y1, r2, g2, y2, blank, walk;
    logic [7:0] cnt_a, cnt_b;
    logic [2:0] phase;

    typedef struct packed {
        logic cl, st, pa, ea, eb, rb, rp;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic        tk;
        logic [26:0] e;
    } row_t;

    in_t         cur;
    row_t        plan[$];
    logic [26:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .i_clk  (clk),
        .i_clr  (clr),
        .i_tick (tick),
        .i_start(start),
        .i_pause(pause),
        .i_emg_a(emg_a),
        .i_emg_b(emg_b),
        .i_req_b(req_b),
        .i_req_p(req_p),
        .o_r1   (r1),
        .o_g1   (g1),
        .o_y1   (y1),
        .o_r2   (r2),
        .o_g2   (g2),
        .o_y2   (y2),
        .o_cnt_a(cnt_a),
        .o_cnt_b(cnt_b),
        .o_blank(blank),
        .o_phase(phase),
        .o_walk (walk)
    );

    function automatic logic [26:0] ev(input logic [2:0] ph,
                                       input int ca, input int cb);
        logic [5:0] l;
        logic [7:0] a, b;
        case (ph)
            3'd1, 3'd5: l = 6'b010100;
            3'd2:       l = 6'b001100;
            3'd3, 3'd6: l = 6'b100010;
            3'd4:       l = 6'b100001;
            default:    l = 6'b100100;
        endcase
        a = ca[7:0];
        b = cb[7:0];
        return {ph, a, b, l, (ph == 3'd0 || ph == 3'd5 || ph == 3'd6),
                (ph == 3'd7)};
    endfunction

    function automatic logic [26:0] obs();
        return {phase, cnt_a, cnt_b, r1, g1, y1, r2, g2, y2, blank, walk};
    endfunction

    // Expected phase after tick t of a cycle that serves the side road once.
    function automatic void cyc_exp(input int t, output logic [2:0] ph,
                                    output int ca, output int cb);
        if (t < 35) begin
            ph = 3'd1; ca = 35 - t; cb = ca + 5;
        end else if (t < 40) begin
            ph = 3'd2; ca = 40 - t; cb = ca;
        end else if (t < 65) begin
            ph = 3'd3; cb = 65 - t; ca = cb + 5;
        end else if (t < 70) begin
            ph = 3'd4; ca = 70 - t; cb = ca;
        end else begin
            ph = 3'd1; ca = 105 - t; cb = ca + 5;
        end
    endfunction

    task automatic add(input logic tk, input logic [2:0] ph,
                       input int ca, input int cb);
        row_t r;
        r.i  = cur;
        r.tk = tk;
        r.e  = ev(ph, ca, cb);
        plan.push_back(r);
    endtask

    task automatic test_reset();
        row_t r;
        logic [26:0] e;
        int k = 0;
        cur = '0;
        cur.st = 1'b1;
        cur.ea = 1'b1;
        add(1'b1, 3'd0, 0, 0);
        add(1'b1, 3'd0, 0, 0);
        cur = '0;
        cur.cl = 1'b1;
        add(1'b0, 3'd0, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {clr, start, pause, emg_a, emg_b, req_b, req_p} = r.i;
            tick = r.tk;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL reset #%0d: got %h want %h", k, obs(), e);
            end
            k++;
        end
    endtask

    task automatic test_ga_reload();
        row_t r;
        logic [26:0] e;
        int k = 0;
        int p, ca;
        cur.st = 1'b1;
        add(1'b0, 3'd1, 35, 40);
        for (int t = 1; t <= 80; t++) begin
            p  = t % 35;
            ca = (p == 0) ? 35 : 35 - p;
            add(1'b1, 3'd1, ca, ca + 5);
        end
        cur.st = 1'b0;
        add(1'b0, 3'd0, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {clr, start, pause, emg_a, emg_b, req_b, req_p} = r.i;
            tick = r.tk;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL ga_reload #%0d: got %h want %h", k, obs(), e);
            end
            k++;
        end
    endtask

    task automatic test_side_ped();
        row_t r;
        logic [26:0] e;
        logic [2:0] ph;
        int k = 0;
        int ca, cb;
        int last = PED ? 85 : 70;
        cur.st = 1'b1;
        add(1'b0, 3'd1, 35, 40);
        for (int t = 1; t <= last; t++) begin
            cur.rb = (t == 3);
            cur.rp = (t == 45);
            if (t < 70) begin
                cyc_exp(t, ph, ca, cb);
            end else if (PED && t < 85) begin
                ph = 3'd7; ca = 85 - t; cb = ca;
            end else begin
                ph = 3'd1; ca = 35; cb = 40;
            end
            add(1'b1, ph, ca, cb);
        end
        cur.rb = 1'b0;
        cur.rp = 1'b0;
        cur.st = 1'b0;
        add(1'b0, 3'd0, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {clr, start, pause, emg_a, emg_b, req_b, req_p} = r.i;
            tick = r.tk;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL side_ped #%0d: got %h want %h", k, obs(), e);
            end
            k++;
        end
    endtask

    // Variant 0: extra requests land in GB/YB and must be ignored.
    // Variant 1: a request on the YA->GB tick must survive the clear.
    task automatic test_pend_b();
        row_t r;
        logic [26:0] e;
        logic [2:0] ph;
        int k = 0;
        int ca, cb;
        for (int v = 0; v < 2; v++) begin
            cur.st = 1'b1;
            add(1'b0, 3'd1, 35, 40);
            for (int t = 1; t <= 105; t++) begin
                cur.rb = (t == 3) || (v == 0 && (t == 50 || t == 66))
                         || (v == 1 && t == 40);
                if (t < 105) cyc_exp(t, ph, ca, cb);
                else if (v == 0) begin ph = 3'd1; ca = 35; cb = 40; end
                else begin ph = 3'd2; ca = 5; cb = 5; end
                add(1'b1, ph, ca, cb);
            end
            cur.rb = 1'b0;
            cur.st = 1'b0;
            add(1'b0, 3'd0, 0, 0);
        end
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {clr, start, pause, emg_a, emg_b, req_b, req_p} = r.i;
            tick = r.tk;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL pend_b #%0d: got %h want %h", k, obs(), e);
            end
            k++;
        end
    endtask

    task automatic test_emergency();
        row_t r;
        logic [26:0] e;
        logic [2:0] ph;
        int k = 0;
        int ca, cb;
        cur.st = 1'b1;
        add(1'b0, 3'd1, 35, 40);
        cur.rb = 1'b1;
        add(1'b1, 3'd1, 34, 39);
        cur.rb = 1'b0;
        for (int t = 2; t <= 45; t++) begin
            cyc_exp(t, ph, ca, cb);
            add(1'b1, ph, ca, cb);
        end
        cur.ea = 1'b1;
        for (int i = 0; i < 11; i++) add(1'b1, 3'd5, 0, 0);
        cur.ea = 1'b0;
        add(1'b0, 3'd1, 35, 40);
        add(1'b1, 3'd1, 34, 39);
        cur.ea = 1'b1;
        cur.eb = 1'b1;
        add(1'b1, 3'd5, 0, 0);
        cur.ea = 1'b0;
        add(1'b1, 3'd6, 0, 0);
        cur.st = 1'b0;
        add(1'b1, 3'd6, 0, 0);
        cur.st = 1'b1;
        cur.eb = 1'b0;
        add(1'b0, 3'd4, 5, 5);
        for (int i = 1; i <= 4; i++) add(1'b1, 3'd4, 5 - i, 5 - i);
        add(1'b1, 3'd1, 35, 40);
        cur.st = 1'b0;
        add(1'b0, 3'd0, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {clr, start, pause, emg_a, emg_b, req_b, req_p} = r.i;
            tick = r.tk;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL emergency #%0d: got %h want %h", k, obs(), e);
            end
            k++;
        end
    endtask

    task automatic test_pause_and_midreset();
        row_t r;
        logic [26:0] e;
        int k = 0;
        cur.st = 1'b1;
        add(1'b0, 3'd1, 35, 40);
        for (int t = 1; t <= 15; t++) add(1'b1, 3'd1, 35 - t, 40 - t);
        cur.pa = 1'b1;
        for (int i = 0; i < 7; i++) add(1'b1, 3'd1, 20, 25);
        add(1'b0, 3'd1, 20, 25);
        cur.pa = 1'b0;
        add(1'b0, 3'd1, 20, 25);
        add(1'b1, 3'd1, 19, 24);
        cur.eb = 1'b1;
        cur.cl = 1'b0;
        add(1'b1, 3'd0, 0, 0);
        cur.cl = 1'b1;
        cur.eb = 1'b0;
        cur.st = 1'b0;
        add(1'b0, 3'd0, 0, 0);
        while (plan.size() > 0) begin
            r = plan.pop_front();
            {clr, start, pause, emg_a, emg_b, req_b, req_p} = r.i;
            tick = r.tk;
            sb.push_back(r.e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL pause #%0d: got %h want %h", k, obs(), e);
            end
            k++;
        end
    endtask

    initial begin
        cur = '0;
        @(posedge clk); #1;
        test_reset();
        test_ga_reload();
        test_side_ped();
        test_pend_b();
        test_emergency();
        test_pause_and_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameters SHALL be: T_GA, default 35, main-road green seconds; T_GB, default 25, side-road green seconds; T_Y, default 5, yellow seconds; T_PED, default 15, pedestrian all-red seconds. All values SHALL be in 2..99.
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 clr  in  1  reset, synchronous, active-low.
REQ-004 tick  in  1  one-clk pulse per second from the external divider.
REQ-005 start  in  1  level; 1 = run the phase cycle, 0 = idle.
REQ-006 pause  in  1  level; 1 = freeze phase and countdowns.
REQ-007 emg_a, emg_b  in  1 each  emergency force main (a) / side (b) green, level.
REQ-008 req_b  in  1  side-road vehicle sensor, pulse or level.
REQ-009 req_p  in  1  pedestrian button, pulse or level; ignored without PED_PHASE_EN.
REQ-010 r1 g1 y1 / r2 g2 y2  out  1 each  main / side lamps, registered, exactly one lit per road.
REQ-011 cnt_a, cnt_b  out  8 each  binary seconds remaining in each road's current colour.
REQ-012 blank  out  1  1 = display shall show dashes, cnt values invalid.
REQ-013 phase  out  3  state code: IDLE=0 GA=1 YA=2 GB=3 YB=4 HOLD_A=5 HOLD_B=6 PED=7.
REQ-014 walk  out  1  pedestrian walk lamp.

Function
REQ-015 Input priority SHALL be, per clk: clr > emg_a > emg_b > start=0 > pause > tick.
REQ-016 IDLE: both roads red, blank=1, cnt_a=cnt_b=0; start=1 SHALL enter GA on the next edge with cnt_a=T_GA and cnt_b=T_GA+T_Y.
REQ-017 On each tick in a timed state (GA/YA/GB/YB/PED), both counts SHALL decrement by 1; the tick on which the current-phase count equals 1 SHALL instead perform the transition and load the new counts.
REQ-018 GA (g1, r2): at expiry, go to YA (cnt_a=cnt_b=T_Y) if pend_b=1; otherwise stay in GA and reload cnt_a=T_GA, cnt_b=T_GA+T_Y.
REQ-019 YA (y1, r2) SHALL go to GB with cnt_b=T_GB and cnt_a=T_GB+T_Y, and SHALL clear pend_b.
REQ-020 GB (r1, g2) SHALL go to YB with cnt_a=cnt_b=T_Y.
REQ-021 YB (r1, y2) SHALL go to PED if the macro is enabled and pend_p=1; otherwise it SHALL go to GA with GA load values.
REQ-022 pend_b SHALL be set by req_b=1 in any state except GB/YB/HOLD_B and cleared only per REQ-019 or reset; a set and a clear in the same cycle SHALL leave pend_b set.
REQ-023 emg_a=1 SHALL enter HOLD_A on the next edge from any state, with g1, r2, blank=1 and counts 0. Release of emg_a SHALL enter GA with GA load values.
REQ-024 emg_b=1 with emg_a=0 SHALL enter HOLD_B on the next edge, with r1, g2 and blank=1. Release SHALL enter YB with cnt_a=cnt_b=T_Y.
REQ-025 start=0 in any non-HOLD state SHALL return to IDLE on the next edge, clearing both pend flags.
REQ-026 pause=1 SHALL hold the state, counts and lamps, and ticks SHALL be ignored; on release, counting SHALL resume from the held values with no skipped tick.
REQ-027 An emergency event coinciding with a tick or an expiry SHALL win, and that tick SHALL be discarded.
REQ-028 Counts SHALL never underflow; a count of 0 in a timed state SHALL be unreachable.

Reset
REQ-029 clr=0 at a clk edge SHALL set phase=IDLE, r1=r2=1, all other lamps 0, cnt_a=cnt_b=0, blank=1, walk=0 and pend_b=pend_p=0.
REQ-030 Reset SHALL override all inputs, including emergencies, mid-phase.

Configuration
REQ-031 With macro PED_PHASE_EN defined: req_p SHALL set pend_p; PED SHALL show all red, walk=1, cnt_a=cnt_b=T_PED, and then go to GA; pend_p SHALL clear on PED entry.
REQ-032 Without PED_PHASE_EN: req_p SHALL be ignored, walk SHALL be tied to 0, pend_p SHALL be absent, and phase 7 SHALL be unreachable.

Verification
REQ-033 clr=0, then start=1 with req_b held at 0 for 80 ticks -> GA reloads at tick 35 and 70; g1 stays lit; cnt_a runs 35..1 and repeats.
REQ-034 req_b pulsed at tick 3 -> YA at tick 35 with cnt 5/5, GB at tick 40 with cnt_a=30, cnt_b=25, YB at tick 65, GA at tick 70.
REQ-035 emg_a asserted mid-GB for 10 ticks -> HOLD_A one clk later with blank=1; release -> GA with cnt_a=35; a tick coinciding with assertion is discarded.
REQ-036 pause high for 7 ticks at cnt_a=20 -> counts frozen at 20; on release the next tick gives 19.
REQ-037 PED_PHASE_EN defined, req_p pulsed during GB -> after YB, PED for 15 ticks with walk=1 and all red, then GA; macro undefined -> YB goes directly to GA.
